r200ifid: RTL and testbench
===========================

Name: r200ifid

Overview:
- IF/ID pipeline register for the r200 core. It sits directly downstream of the fetch stage and consumes its instruction word, PC and PC+4.
- Presents a registered instruction and PC context to decode, inserts bubbles on taken branch/jump (flush), and holds on hazard stall.
- Drives the fetch stage's next-PC select and PC+4-hold value.
- Keeps saturating stall and flush event counters for performance debug.

Parameters:
- NOP, 32'h0000_0000, instruction word injected on flush and reset (sll $0,$0,0).
- CNTW, 16, width of the stall and flush event counters.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- if_instrn  in  32  instruction word from fetch.
- if_pc  in  32  address of if_instrn.
- if_pcp4  in  32  if_pc + 4 from fetch adder.
- stall  in  1  hazard-unit hold request for the ID slot.
- br_taken  in  1  branch in ID resolved taken.
- jump  in  1  jump in ID.
- id_instrn  out  32  registered instruction to decode.
- id_pc  out  32  registered PC of id_instrn.
- id_pcp4  out  32  registered PC+4 of id_instrn; also branch-target base.
- id_valid  out  1  ID slot holds a real instruction, not a bubble.
- pcp4_hold  out  32  refetch address for fetch during stall; equals id_pcp4.
- pcsel  out  2  fetch next-PC select: 00 pcp4, 01 brtarg, 10 jumptarg, 11 pcp4_hold.
- stall_cnt  out  CNTW  count of stalled cycles.
- flush_cnt  out  CNTW  count of flushes.

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: id_instrn=NOP, id_pc=0, id_pcp4=0, id_valid=0, stall_cnt=0, flush_cnt=0.
- Redirect: redirect = (br_taken | jump) & id_valid & ~stall. br_taken/jump are ignored when id_valid=0 or stall=1; a stalled branch redirects in its first unstalled cycle.
- Update priority each edge: rst > redirect > stall > load.
  - redirect: id_instrn<=NOP, id_valid<=0, id_pc/id_pcp4<=0. The wrong-path fetch is discarded.
  - stall: all ID registers hold.
  - load: id_instrn<=if_instrn, id_pc<=if_pc, id_pcp4<=if_pcp4, id_valid<=1.
- Latency: one cycle from fetch outputs to ID outputs.
- pcsel is combinational from the current inputs and state:
  - rst=1 -> 00.
  - else stall=1 -> 11.
  - else redirect with jump=1 -> 10 (jump wins if br_taken and jump are both asserted).
  - else redirect with br_taken=1 -> 01.
  - else -> 00.
- pcp4_hold = id_pcp4 combinationally. In sequential flow this is the address currently in fetch, so stalling refetches that instruction and does not skip it.
- stall_cnt increments on each non-reset edge with stall=1.
- flush_cnt increments on each non-reset edge with redirect=1.
- Both counters saturate at all-ones and do not wrap.
- Reset mid-stall or mid-redirect: reset wins; the next cycle is an empty slot with pcsel=00.
- Consecutive redirects: the bubble has id_valid=0, so a second redirect cannot fire from the bubble.

Decomposition:
- Shared package r200_pkg holds:
  - the NOP encoding;
  - pcsel encodings PCSEL_PCP4=2'b00, PCSEL_BR=2'b01, PCSEL_JUMP=2'b10, PCSEL_HOLD=2'b11 (fetch's mux4w32 uses the same values).
- One sub-module, r200satcnt: parameterised CNTW saturating counter with clk, rst, inc and cnt ports. It is instantiated twice, for stall and flush.

Test Plan:
- Reset: hold rst=1 for 2 cycles with if_instrn=32'h2001_0005 -> id_instrn=0, id_valid=0, counters 0, pcsel=00. Release rst -> next edge loads id_instrn=32'h2001_0005, id_pc=if_pc, id_valid=1.
- Stall: load if_pc=0x40 (id_pcp4 becomes 0x44), then assert stall for 3 cycles while changing if_instrn -> ID outputs frozen, pcsel=11, pcp4_hold=0x44, stall_cnt=3.
- Branch flush: ID holds a valid instruction; assert br_taken=1 -> pcsel=01 in that cycle; next edge id_instrn=NOP, id_valid=0, flush_cnt=1. br_taken held high next cycle -> no second flush.
- Stall plus branch: stall=1 and br_taken=1 together -> pcsel=11, no flush. Deassert stall -> pcsel=01 and flush on that edge.
- Jump/branch conflict: jump=1 and br_taken=1 with id_valid=1 -> pcsel=10, flush_cnt increments by 1.
- Saturation: CNTW=4, hold stall for 20 cycles -> stall_cnt reaches 15 and stays 15. Reset mid-stall -> all outputs return to reset values on the next edge.

Source files
------------

// File: rtl/r200_pkg.sv
// Shared r200 pipeline constants: the injected bubble instruction and the
// fetch next-PC select encodings (fetch's mux4w32 decodes the same values).
package r200_pkg;

    // sll $0,$0,0 -- architectural no-op used for bubbles and reset.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // Fetch next-PC select.
    localparam logic [1:0] PCSEL_PCP4 = 2'b00;  // sequential PC+4
    localparam logic [1:0] PCSEL_BR   = 2'b01;  // branch target
    localparam logic [1:0] PCSEL_JUMP = 2'b10;  // jump target
    localparam logic [1:0] PCSEL_HOLD = 2'b11;  // refetch pcp4_hold

endpackage

// File: rtl/r200ifid_satcnt.sv
// Saturating event counter: counts rising edges with inc=1, sticks at all-ones.
module r200satcnt #(
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            inc,
    output logic [CNTW-1:0] cnt
);

    logic [CNTW-1:0] cnt_q;
    logic [CNTW-1:0] cnt_d;

    // Next count: advance on inc unless already saturated.
    always_comb begin
        // NOTE: default assignment first so no path leaves cnt_d unassigned (no latch).
        cnt_d = cnt_q;
        if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNTW'(1);
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments for state so all flops update together at the edge.
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/r200ifid.sv
// r200 IF/ID pipeline register: registers fetch's instruction/PC context for
// decode, injects bubbles on taken branch/jump, holds on hazard stall, steers
// fetch's next-PC mux and keeps saturating stall/flush counters.
module r200ifid
    import r200_pkg::*;
#(
    parameter logic [31:0] NOP  = NOP_INSTR,
    parameter int          CNTW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     if_instrn,
    input  logic [31:0]     if_pc,
    input  logic [31:0]     if_pcp4,
    input  logic            stall,
    input  logic            br_taken,
    input  logic            jump,
    output logic [31:0]     id_instrn,
    output logic [31:0]     id_pc,
    output logic [31:0]     id_pcp4,
    output logic            id_valid,
    output logic [31:0]     pcp4_hold,
    output logic [1:0]      pcsel,
    output logic [CNTW-1:0] stall_cnt,
    output logic [CNTW-1:0] flush_cnt
);

    logic [31:0] instrn_q, instrn_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pcp4_q, pcp4_d;
    logic        valid_q, valid_d;
    logic        redirect;

    // A bubble or a stalled slot can never redirect; a stalled branch fires
    // in its first unstalled cycle.
    assign redirect = (br_taken | jump) & valid_q & ~stall;

    // ID slot next state: redirect > stall > load (reset handled in the flop).
    always_comb begin
        instrn_d = instrn_q;
        pc_d     = pc_q;
        pcp4_d   = pcp4_q;
        valid_d  = valid_q;
        if (redirect) begin
            instrn_d = NOP;
            pc_d     = '0;
            pcp4_d   = '0;
            valid_d  = 1'b0;
        end else if (!stall) begin
            instrn_d = if_instrn;
            pc_d     = if_pc;
            pcp4_d   = if_pcp4;
            valid_d  = 1'b1;
        end
    end

    // ID slot registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            instrn_q <= NOP;
            pc_q     <= '0;
            pcp4_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            instrn_q <= instrn_d;
            pc_q     <= pc_d;
            pcp4_q   <= pcp4_d;
            valid_q  <= valid_d;
        end
    end

    // Fetch next-PC select; jump wins over a simultaneous taken branch.
    always_comb begin
        pcsel = PCSEL_PCP4;
        if (rst) begin
            pcsel = PCSEL_PCP4;
        end else if (stall) begin
            pcsel = PCSEL_HOLD;
        end else if (redirect && jump) begin
            pcsel = PCSEL_JUMP;
        end else if (redirect) begin
            pcsel = PCSEL_BR;
        end
    end

    // During a stall the address in fetch is id_pcp4, so refetch it.
    assign pcp4_hold = pcp4_q;

    assign id_instrn = instrn_q;
    assign id_pc     = pc_q;
    assign id_pcp4   = pcp4_q;
    assign id_valid  = valid_q;

    r200satcnt #(.CNTW(CNTW)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (stall),
        .cnt (stall_cnt)
    );

    r200satcnt #(.CNTW(CNTW)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc (redirect),
        .cnt (flush_cnt)
    );

endmodule

// File: tb/tb_r200ifid.sv
// Scoreboard bench for r200ifid: the driver applies directed then random
// cycles, a behavioural model pushes expected pcsel and post-edge state into
// queues, and two monitors pop and compare against the DUT.
module tb_r200ifid;

    localparam int CNTW = 4;
    localparam int CMAX = (1 << CNTW) - 1;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pcp4;
        logic        valid;
        int          sc;
        int          fc;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [31:0]     if_instrn = '0;
    logic [31:0]     if_pc = '0;
    logic [31:0]     if_pcp4 = 32'd4;
    logic            stall = 1'b0;
    logic            br_taken = 1'b0;
    logic            jump = 1'b0;
    logic [31:0]     id_instrn, id_pc, id_pcp4, pcp4_hold;
    logic            id_valid;
    logic [1:0]      pcsel;
    logic [CNTW-1:0] stall_cnt, flush_cnt;

    int vectors = 0;
    int miscompares = 0;

    exp_t        st_q[$];
    logic [1:0]  pcsel_q[$];

    // Behavioural model of the ID slot.
    logic [31:0] m_instr = '0;
    logic [31:0] m_pc = '0;
    logic [31:0] m_pcp4 = '0;
    logic        m_valid = 1'b0;
    int          m_sc = 0;
    int          m_fc = 0;

    r200ifid #(.CNTW(CNTW)) dut (
        .clk       (clk),
        .rst       (rst),
        .if_instrn (if_instrn),
        .if_pc     (if_pc),
        .if_pcp4   (if_pcp4),
        .stall     (stall),
        .br_taken  (br_taken),
        .jump      (jump),
        .id_instrn (id_instrn),
        .id_pc     (id_pc),
        .id_pcp4   (id_pcp4),
        .id_valid  (id_valid),
        .pcp4_hold (pcp4_hold),
        .pcsel     (pcsel),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // One clock cycle of stimulus; the model predicts pcsel for the current
    // state and the state after the coming edge.
    task automatic step(input logic r, input logic [31:0] ins, input logic [31:0] pc,
                        input logic st, input logic br, input logic jp);
        logic       redir;
        logic [1:0] exp_sel;
        exp_t       e;
        @(negedge clk);
        rst       = r;
        if_instrn = ins;
        if_pc     = pc;
        if_pcp4   = pc + 32'd4;
        stall     = st;
        br_taken  = br;
        jump      = jp;
        #2;
        redir = (br || jp) && m_valid && !st;
        if (r)               exp_sel = 2'b00;
        else if (st)         exp_sel = 2'b11;
        else if (redir && jp) exp_sel = 2'b10;
        else if (redir)      exp_sel = 2'b01;
        else                 exp_sel = 2'b00;
        pcsel_q.push_back(exp_sel);
        if (r) begin
            m_instr = '0; m_pc = '0; m_pcp4 = '0; m_valid = 1'b0;
            m_sc = 0; m_fc = 0;
        end else begin
            if (st && m_sc < CMAX)    m_sc = m_sc + 1;
            if (redir && m_fc < CMAX) m_fc = m_fc + 1;
            if (redir) begin
                m_instr = '0; m_pc = '0; m_pcp4 = '0; m_valid = 1'b0;
            end else if (!st) begin
                m_instr = ins; m_pc = pc; m_pcp4 = pc + 32'd4; m_valid = 1'b1;
            end
        end
        e.instr = m_instr; e.pc = m_pc; e.pcp4 = m_pcp4; e.valid = m_valid;
        e.sc = m_sc; e.fc = m_fc;
        st_q.push_back(e);
    endtask

    // pcsel monitor: compares combinational select mid low-phase.
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (pcsel_q.size() > 0) begin
                logic [1:0] s;
                s = pcsel_q.pop_front();
                check("pcsel", {30'd0, pcsel}, {30'd0, s});
            end
        end
    end

    // State monitor: compares registered outputs just after each edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (st_q.size() > 0) begin
                exp_t e;
                e = st_q.pop_front();
                check("id_instrn", id_instrn, e.instr);
                check("id_pc", id_pc, e.pc);
                check("id_pcp4", id_pcp4, e.pcp4);
                check("id_valid", {31'd0, id_valid}, {31'd0, e.valid});
                check("pcp4_hold", pcp4_hold, e.pcp4);
                check("stall_cnt", {{(32-CNTW){1'b0}}, stall_cnt}, 32'(e.sc));
                check("flush_cnt", {{(32-CNTW){1'b0}}, flush_cnt}, 32'(e.fc));
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset held two cycles with a live instruction on the fetch side.
        step(1, 32'h2001_0005, 32'h0000_0100, 0, 0, 0);
        step(1, 32'h2001_0005, 32'h0000_0100, 0, 0, 0);
        // Release: first edge loads the fetch word.
        step(0, 32'h2001_0005, 32'h0000_0100, 0, 0, 0);
        // Load PC 0x40, then stall three cycles with changing fetch words.
        step(0, 32'h1111_0040, 32'h0000_0040, 0, 0, 0);
        step(0, 32'hAAAA_0001, 32'h0000_0044, 1, 0, 0);
        step(0, 32'hAAAA_0002, 32'h0000_0044, 1, 0, 0);
        step(0, 32'hAAAA_0003, 32'h0000_0044, 1, 0, 0);
        // Resume, then taken branch; held branch on the bubble must not refire.
        step(0, 32'h2222_0044, 32'h0000_0044, 0, 0, 0);
        step(0, 32'h3333_0048, 32'h0000_0048, 0, 1, 0);
        step(0, 32'h4444_0200, 32'h0000_0200, 0, 1, 0);
        // Stall with branch: hold, no flush; release stall: flush.
        step(0, 32'h5555_0204, 32'h0000_0204, 0, 0, 0);
        step(0, 32'h6666_0208, 32'h0000_0208, 1, 1, 0);
        step(0, 32'h6666_0208, 32'h0000_0208, 0, 1, 0);
        // Jump and branch together: jump wins, single flush.
        step(0, 32'h7777_0300, 32'h0000_0300, 0, 0, 0);
        step(0, 32'h8888_0304, 32'h0000_0304, 0, 1, 1);
        // Long stall to saturate the counter, then reset mid-stall.
        step(0, 32'h9999_0400, 32'h0000_0400, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            step(0, $urandom, 32'h0000_0404, 1, 0, 0);
        end
        step(1, 32'hBBBB_0000, 32'h0000_0500, 1, 1, 0);
        step(0, 32'hCCCC_0504, 32'h0000_0504, 0, 0, 0);
        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            logic r, s, b, j;
            r = ($urandom_range(0, 99) < 2);
            s = ($urandom_range(0, 99) < 25);
            b = ($urandom_range(0, 99) < 20);
            j = ($urandom_range(0, 99) < 10);
            step(r, $urandom, {$urandom_range(0, 32'h0FFF_FFFF), 2'b00}, s, b, j);
        end
        @(posedge clk);
        #4;
        check("pcsel_queue_drained", 32'(pcsel_q.size()), 32'd0);
        check("state_queue_drained", 32'(st_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
